aes128_key_expander: RTL and testbench
======================================

// Module: aes128_key_expander
// PURPOSE
//  Iterative AES-128 key schedule between the requestor's key_out/key_valid_out and the
//  aes128 cipher rounds. Captures one 128-bit cipher key and produces round keys 0..10
//  at one per clock. Streams each round key as it is made and stores all 11 in a register
//  file that the cipher reads by round index.
// PARAMETERS
//  NUM_ROUNDS  10  last round-key index produced; fixed at 10 for AES-128
// PORTS
//  clk            in   1    clock; the single clock domain
//  reset          in   1    synchronous, active-low reset (asserted when 0)
//  key_in         in   128  cipher key; word w0 = key_in[127:96] ... w3 = key_in[31:0]
//  key_valid_in   in   1    level; a 0->1 transition requests expansion of key_in
//  rk_rd_addr     in   4    round-key read index, 0..10
//  rk_rd_data     out  128  round key at rk_rd_addr; registered, 1-cycle read latency
//  rk_out         out  128  streamed round key just written
//  rk_idx         out  4    index of rk_out
//  rk_valid       out  1    1-cycle strobe qualifying rk_out/rk_idx
//  busy           out  1    high while in S_EXPAND
//  keys_ready     out  1    high once all 11 round keys are stored; cleared by a new key edge
// BEHAVIOUR
//  - Reset (reset==0 at posedge):
//    - state=S_IDLE; all outputs 0; all 11 stored keys 0.
//    - key_valid_q (delayed key_valid_in) = 0, so key_valid_in already high after reset
//      counts as an edge.
//  - Edge detect: key_edge = key_valid_in & ~key_valid_q; key_valid_q updates every cycle.
//  - FSM states: S_IDLE, S_EXPAND, S_READY.
//  - key_edge in any state (posedge N):
//    - rk[0]<=key_in, work<=key_in, round<=1, rcon<=8'h01.
//    - keys_ready<=0; state<=S_EXPAND.
//    - rk_valid<=1 with rk_idx=0, rk_out=key_in.
//    - key_edge during S_EXPAND aborts the current schedule and restarts.
//  - S_EXPAND, each cycle with no key_edge:
//    - t  = SubWord(RotWord(w3)) ^ {rcon,24'h0}, where RotWord({a,b,c,d}) = {b,c,d,a}.
//    - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
//    - rk[round]<=work<={w0',w1',w2',w3'}.
//    - rk_valid<=1, rk_idx<=round.
//    - round<=round+1; rcon<=xtime(rcon), where xtime = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1B : 0).
//    - rcon sequence: 01 02 04 08 10 20 40 80 1B 36.
//  - When round==10 is written (posedge N+10): state<=S_READY, keys_ready<=1.
//    - Latency: key edge sampled at posedge N; all keys valid and keys_ready=1 after
//      posedge N+10 (11 rk_valid strobes, idx 0..10 on consecutive cycles).
//  - S_READY: holds until the next key_edge. Level-high key_valid_in (the requestor holds
//    it) causes no re-expansion.
//  - SubWord: 4 parallel S-box lookups via aes128_pkg::sbox(); combinational, 1 round/cycle.
//  - rk_rd_data <= (rk_rd_addr<=10) ? rk[rk_rd_addr] : 128'h0, every cycle.
//    - Reads during S_EXPAND return current contents (old or new key). Consumers gate on
//      keys_ready.
//  - Same-cycle write to rk[i] and read of addr i: read returns the old value; the new
//    value appears on the next read.
//  - Reset mid-expansion: immediate return to S_IDLE, storage cleared, no further rk_valid.
//  - No backpressure: rk_valid strobes are not stallable; a downstream consumer must accept
//    1 key/cycle.
// TESTING
//  - FIPS-197 key: key_in=2b7e151628aed2a6abf7158809cf4f3c, raise key_valid_in ->
//    - rk1=a0fafe1788542cb123a339392a6c7605.
//    - rk10=d014f9a8c9ee2589e13f0cc8b6630ca6.
//    - keys_ready exactly 10 cycles after the capture edge.
//  - Zero key: key_in=0 ->
//    - rk1=62636363626363636263636362636363.
//    - rk10=b4ef5bcb3e92e21123e951cf6f8f188e.
//    - 11 rk_valid strobes, rk_idx 0..10 in order.
//  - Hold key_valid_in high 50 cycles after ready -> no further rk_valid; keys_ready stays 1.
//    - Drop then raise key_valid_in with a new key -> keys_ready falls, full re-expansion.
//  - New key edge at round 5 -> restart from idx 0 with the new key; the final rk10 matches
//    the new key's golden value.
//  - Assert reset at round 7 -> next cycle busy=0, keys_ready=0, rk_rd_data=0 for all addrs.
//    - key_valid_in held high through reset release -> expansion starts.
//  - Read sweep after ready: addr 0..15 -> rk0..rk10 with 1-cycle latency; addr 11..15 -> 0.

Source files
------------

// File: rtl/aes128_key_expander_if.sv
// Handshake/bus bundle between the key requestor / round consumer and the
// AES-128 key expander. The requestor side is the master; the expander is
// the slave.
interface aes128_key_expander_if;
  logic [127:0] key_in;
  logic         key_valid_in;
  logic [3:0]   rk_rd_addr;
  logic [127:0] rk_rd_data;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic         busy;
  logic         keys_ready;

  modport master (
    output key_in, key_valid_in, rk_rd_addr,
    input  rk_rd_data, rk_out, rk_idx, rk_valid, busy, keys_ready
  );

  modport slave (
    input  key_in, key_valid_in, rk_rd_addr,
    output rk_rd_data, rk_out, rk_idx, rk_valid, busy, keys_ready
  );
endinterface

// File: rtl/aes128_key_expander.sv
// Iterative AES-128 key schedule: captures a cipher key on a rising
// key_valid_in, produces one round key per clock (rounds 0..10), streams
// each as it is made and keeps all of them in a registered-read file.
package aes128_pkg;
  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply, shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        acc = acc ^ sh;
      end else begin
        acc = acc;
      end
      sh = xtime(sh);
    end
    return acc;
  endfunction

  // AES S-box: multiplicative inverse (a^254, which maps 0 to 0) followed
  // by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] pw;
    inv = 8'h01;
    pw  = a;
    for (int i = 1; i < 8; i++) begin
      pw  = gf_mul(pw, pw);
      inv = gf_mul(inv, pw);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction
endpackage

module aes128_key_expander #(
  parameter int NUM_ROUNDS = 10
) (
  input logic                 clk,
  input logic                 reset,
  aes128_key_expander_if.slave kx
);
  import aes128_pkg::*;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_READY  = 2'd2
  } state_t;

  state_t       state_r;
  state_t       next_state_s;
  logic         key_valid_q_r;
  logic         key_edge_s;
  logic         last_round_s;
  logic [127:0] work_r;
  logic [3:0]   round_r;
  logic [7:0]   rcon_r;
  logic [127:0] rk_r [0:NUM_ROUNDS];
  logic [31:0]  t_s;
  logic [31:0]  w0_s;
  logic [31:0]  w1_s;
  logic [31:0]  w2_s;
  logic [31:0]  w3_s;
  logic [127:0] next_work_s;

  assign key_edge_s   = kx.key_valid_in & ~key_valid_q_r;
  assign last_round_s = (round_r == 4'(NUM_ROUNDS));

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state: a key edge always (re)starts expansion; otherwise expansion
  // runs until the last round key is written, then holds in S_READY.
  always_comb begin
    next_state_s = state_r;
    if (key_edge_s) begin
      next_state_s = S_EXPAND;
    end else begin
      case (state_r)
        S_IDLE:   next_state_s = S_IDLE;
        S_EXPAND: begin
          if (last_round_s) begin
            next_state_s = S_READY;
          end else begin
            next_state_s = S_EXPAND;
          end
        end
        S_READY:  next_state_s = S_READY;
        default:  next_state_s = S_IDLE;
      endcase
    end
  end

  // One key-schedule round from the current working key.
  always_comb begin
    t_s         = sub_word(rot_word(work_r[31:0])) ^ {rcon_r, 24'h000000};
    w0_s        = work_r[127:96] ^ t_s;
    w1_s        = work_r[95:64]  ^ w0_s;
    w2_s        = work_r[63:32]  ^ w1_s;
    w3_s        = work_r[31:0]   ^ w2_s;
    next_work_s = {w0_s, w1_s, w2_s, w3_s};
  end

  // Datapath: edge register, round-key file, streamed output, status flags
  // and the registered read port (reads see the pre-write contents).
  always_ff @(posedge clk) begin
    if (!reset) begin
      key_valid_q_r <= 1'b0;
      work_r        <= 128'h0;
      round_r       <= 4'd0;
      rcon_r        <= 8'h00;
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        rk_r[i] <= 128'h0;
      end
      kx.rk_rd_data <= 128'h0;
      kx.rk_out     <= 128'h0;
      kx.rk_idx     <= 4'd0;
      kx.rk_valid   <= 1'b0;
      kx.busy       <= 1'b0;
      kx.keys_ready <= 1'b0;
    end else begin
      key_valid_q_r <= kx.key_valid_in;
      kx.rk_rd_data <= (kx.rk_rd_addr <= 4'(NUM_ROUNDS)) ? rk_r[kx.rk_rd_addr] : 128'h0;
      kx.busy       <= (next_state_s == S_EXPAND);
      kx.rk_valid   <= 1'b0;
      if (key_edge_s) begin
        rk_r[0]       <= kx.key_in;
        work_r        <= kx.key_in;
        round_r       <= 4'd1;
        rcon_r        <= 8'h01;
        kx.keys_ready <= 1'b0;
        kx.rk_valid   <= 1'b1;
        kx.rk_idx     <= 4'd0;
        kx.rk_out     <= kx.key_in;
      end else if (state_r == S_EXPAND) begin
        rk_r[round_r] <= next_work_s;
        work_r        <= next_work_s;
        kx.rk_valid   <= 1'b1;
        kx.rk_idx     <= round_r;
        kx.rk_out     <= next_work_s;
        round_r       <= round_r + 4'd1;
        rcon_r        <= xtime(rcon_r);
        if (last_round_s) begin
          kx.keys_ready <= 1'b1;
        end else begin
          kx.keys_ready <= 1'b0;
        end
      end else begin
        work_r <= work_r;
      end
    end
  end
endmodule

// File: tb/tb_aes128_key_expander.sv
// Scoreboarded bench for aes128_key_expander: issued keys push their full
// expected schedule (from a word-level FIPS-197 model) into a queue that a
// negedge monitor drains on every rk_valid strobe.
module tb_aes128_key_expander;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  aes128_key_expander_if kif();
  aes128_key_expander dut (.clk(clk), .reset(reset), .kx(kif));

  typedef logic [10:0][127:0] rk_arr_t;
  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;

  exp_t    exp_q[$];
  rk_arr_t cur_rk;
  int      n_cmp = 0;
  int      n_err = 0;
  logic [7:0] sb [0:255];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic int rotl8(input int v, input int s);
    return ((v << s) | (v >> (8 - s))) & 'hff;
  endfunction

  // S-box by walking the generator 3 and its inverse through GF(2^8).
  task automatic build_sbox();
    int p, q, x;
    p = 1;
    q = 1;
    do begin
      p = (p ^ (p << 1) ^ (((p & 'h80) != 0) ? 'h1b : 0)) & 'hff;
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      q = q & 'hff;
      if ((q & 'h80) != 0) q = q ^ 'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sb[p] = 8'(x ^ 'h63);
    end while (p != 1);
    sb[0] = 8'h63;
  endtask

  // FIPS-197 word-array key expansion.
  function automatic rk_arr_t expand_model(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    int          rc;
    rk_arr_t     r;
    rc = 1;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t  = t ^ {rc[7:0], 24'h000000};
        rc = rc << 1;
        if (rc > 'hff) rc = rc ^ 'h11b;
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int j = 0; j < 11; j++) r[j] = {w[4 * j], w[4 * j + 1], w[4 * j + 2], w[4 * j + 3]};
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [127:0] key);
    cur_rk = expand_model(key);
    for (int j = 0; j < 11; j++) exp_q.push_back({4'(j), cur_rk[j]});
  endtask

  // Drop key_valid_in for a cycle, then raise it with the new key.
  task automatic start_key(input logic [127:0] key);
    kif.key_valid_in = 1'b0;
    tick();
    kif.key_in       = key;
    kif.key_valid_in = 1'b1;
    push_exp(key);
  endtask

  task automatic wait_drain(input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      tick();
      c++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d strobes outstanding after %0d cycles, required 0", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic check_pending(input string name, input int req);
    n_cmp++;
    if (exp_q.size() != req) begin
      n_err++;
      $display("FAIL %s: %0d strobes pending, required %0d", name, exp_q.size(), req);
    end
  endtask

  // Read every address; data must lag the address by exactly one clock.
  task automatic read_sweep(input string tag);
    logic [127:0] prev;
    prev = 128'h0;
    for (int a = 0; a < 16; a++) begin
      kif.rk_rd_addr = 4'(a);
      #1;
      if (a > 0) check($sformatf("%s_hold_a%0d", tag, a), kif.rk_rd_data, prev);
      tick();
      prev = (a <= 10) ? cur_rk[a] : 128'h0;
      check($sformatf("%s_rd_a%0d", tag, a), kif.rk_rd_data, prev);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (kif.rk_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_strobe: idx %0d out %h, required no strobe", kif.rk_idx, kif.rk_out);
      end else begin
        e = exp_q.pop_front();
        check("rk_idx", 128'(kif.rk_idx), 128'(e.idx));
        check($sformatf("rk_out_%0d", e.idx), kif.rk_out, e.key);
        check($sformatf("keys_ready_at_%0d", e.idx), 128'(kif.keys_ready), 128'(e.idx == 4'd10));
        check($sformatf("busy_at_%0d", e.idx), 128'(kif.busy), 128'(e.idx != 4'd10));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  initial begin
    rk_arr_t r;
    logic [127:0] k;
    build_sbox();
    kif.key_in       = 128'h0;
    kif.key_valid_in = 1'b0;
    kif.rk_rd_addr   = 4'd0;
    reset            = 1'b0;
    repeat (3) tick();
    check("reset_busy", 128'(kif.busy), 128'h0);
    check("reset_keys_ready", 128'(kif.keys_ready), 128'h0);
    check("reset_rk_valid", 128'(kif.rk_valid), 128'h0);
    check("reset_rk_out", kif.rk_out, 128'h0);
    check("reset_rk_idx", 128'(kif.rk_idx), 128'h0);
    check("reset_rd_data", kif.rk_rd_data, 128'h0);
    reset = 1'b1;

    r = expand_model(FIPS_KEY);
    check("model_fips_rk1", r[1], FIPS_RK1);
    check("model_fips_rk10", r[10], FIPS_RK10);
    r = expand_model(128'h0);
    check("model_zero_rk1", r[1], ZERO_RK1);
    check("model_zero_rk10", r[10], ZERO_RK10);

    // FIPS-197 key, then a full read sweep.
    start_key(FIPS_KEY);
    wait_drain(20);
    read_sweep("fips");

    // All-zero key.
    start_key(128'h0);
    wait_drain(20);
    kif.rk_rd_addr = 4'd10;
    tick();
    tick();
    check("zero_rd_rk10", kif.rk_rd_data, ZERO_RK10);

    // Level-high key_valid_in must not re-trigger expansion.
    for (int i = 0; i < 50; i++) begin
      tick();
      check("hold_keys_ready", 128'(kif.keys_ready), 128'h1);
    end

    // Random keys, each followed by a random read.
    for (int n = 0; n < 5; n++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      start_key(k);
      wait_drain(20);
      repeat ($urandom_range(0, 3)) tick();
      kif.rk_rd_addr = 4'($urandom_range(0, 15));
      tick();
      check("rand_rd", kif.rk_rd_data, (kif.rk_rd_addr <= 4'd10) ? cur_rk[kif.rk_rd_addr] : 128'h0);
    end

    // New key edge while round 5 is due: restart with the new key.
    start_key({$urandom(), $urandom(), $urandom(), $urandom()});
    repeat (4) tick();
    kif.key_valid_in = 1'b0;
    tick();
    check_pending("abort_point", 6);
    exp_q.delete();
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    kif.key_in       = k;
    kif.key_valid_in = 1'b1;
    push_exp(k);
    wait_drain(20);
    read_sweep("restart");

    // Reset while round 7 is due, key_valid_in low: everything cleared.
    start_key({$urandom(), $urandom(), $urandom(), $urandom()});
    repeat (7) tick();
    check_pending("reset_point", 4);
    exp_q.delete();
    reset            = 1'b0;
    kif.key_valid_in = 1'b0;
    tick();
    check("midreset_busy", 128'(kif.busy), 128'h0);
    check("midreset_keys_ready", 128'(kif.keys_ready), 128'h0);
    check("midreset_rk_valid", 128'(kif.rk_valid), 128'h0);
    check("midreset_rd_data", kif.rk_rd_data, 128'h0);
    reset = 1'b1;
    tick();
    cur_rk = '0;
    read_sweep("cleared");

    // Reset at round 7 with key_valid_in held high through release.
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    start_key(k);
    repeat (7) tick();
    exp_q.delete();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    push_exp(k);
    wait_drain(20);
    read_sweep("rearm");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
